// File: rtl/fifo_param.sv
// Parameterised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky misuse flag and a choice of registered-read or first-word-fall-through output.
module fifo_param #(
    parameter int tamano_datos    = 10,
    parameter int tamano_direcion = 3,
    parameter bit FWFT            = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic                       read_enable,
    input  logic [tamano_datos-1:0]    data_in,
    input  logic [tamano_direcion:0]   umbral_alto,
    input  logic [tamano_direcion:0]   umbral_bajo,
    output logic [tamano_datos-1:0]    data_out,
    output logic                       valid,
    output logic [tamano_direcion:0]   count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       error
);

    localparam logic [tamano_direcion:0]   CNT_ZERO = {(tamano_direcion+1){1'b0}};
    localparam logic [tamano_direcion:0]   CNT_ONE  = {{tamano_direcion{1'b0}}, 1'b1};
    localparam logic [tamano_direcion:0]   CNT_FULL = {1'b1, {tamano_direcion{1'b0}}};
    localparam logic [tamano_direcion-1:0] PTR_ZERO = {tamano_direcion{1'b0}};
    localparam logic [tamano_direcion-1:0] PTR_ONE  = {{(tamano_direcion-1){1'b0}}, 1'b1};
    localparam logic [tamano_datos-1:0]    DATA_ZERO = {tamano_datos{1'b0}};

    logic [tamano_datos-1:0]    mem_r [2**tamano_direcion];
    logic [tamano_direcion-1:0] wr_ptr_r;
    logic [tamano_direcion-1:0] rd_ptr_r;
    logic [tamano_direcion:0]   count_r;
    logic [tamano_direcion:0]   count_nxt_s;
    logic                       full_r;
    logic                       empty_r;
    logic                       error_r;
    logic                       rd_acc_s;
    logic                       wr_acc_s;
    logic                       err_evt_s;

    // Handshake decode: a full FIFO still takes a write when a read frees a slot on the same edge.
    always_comb begin
        rd_acc_s  = read_enable & ~empty_r;
        wr_acc_s  = write_enable & (~full_r | rd_acc_s);
        err_evt_s = (write_enable & ~wr_acc_s) | (read_enable & empty_r);
    end

    // Next occupancy from the accepted operations.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, registered full/empty and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            error_r  <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == CNT_ZERO);
            if (err_evt_s) begin
                error_r <= 1'b1;
            end
        end
    end

    // Storage array; deliberately not reset, stale words become unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented directly; masked to zero while empty so nothing stale leaks out.
            always_comb begin
                if (empty_r) begin
                    data_out = DATA_ZERO;
                end else begin
                    data_out = mem_r[rd_ptr_r];
                end
                valid = ~empty_r;
            end
        end else begin : g_reg
            logic [tamano_datos-1:0] data_out_r;
            logic                    valid_r;

            // Registered read port: popped word captured on the read edge, valid pulses one cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_out_r <= DATA_ZERO;
                    valid_r    <= 1'b0;
                end else begin
                    if (rd_acc_s) begin
                        data_out_r <= mem_r[rd_ptr_r];
                    end
                    valid_r <= rd_acc_s;
                end
            end

            assign data_out = data_out_r;
            assign valid    = valid_r;
        end
    endgenerate

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign error        = error_r;
    assign almost_full  = (count_r >= umbral_alto);
    assign almost_empty = (count_r <= umbral_bajo);

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench: a registered-read and a FWFT instance share stimulus and are compared
// against a queue-based reference of FIFO behaviour.
module tb_fifo_param;

    localparam int W = 10;
    localparam int A = 3;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         we;
    logic         re;
    logic [W-1:0] din;
    logic [A:0]   ua;
    logic [A:0]   ub;

    logic [W-1:0] dout0, dout1;
    logic         v0, v1, f0, f1, e0, e1, af0, af1, ae0, ae1, er0, er1;
    logic [A:0]   cnt0, cnt1;

    logic [W-1:0] q[$];
    bit           m_err;
    bit           m_valid;
    logic [W-1:0] m_dout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_param #(.tamano_datos(W), .tamano_direcion(A), .FWFT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .write_enable(we), .read_enable(re), .data_in(din),
        .umbral_alto(ua), .umbral_bajo(ub), .data_out(dout0), .valid(v0), .count(cnt0),
        .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0), .error(er0)
    );

    fifo_param #(.tamano_datos(W), .tamano_direcion(A), .FWFT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .write_enable(we), .read_enable(re), .data_in(din),
        .umbral_alto(ua), .umbral_bajo(ub), .data_out(dout1), .valid(v1), .count(cnt1),
        .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1), .error(er1)
    );

    // One clock of stimulus with the reference updated from the FIFO rules; no checking here.
    task automatic cycle(input bit w, input bit r, input logic [W-1:0] d);
        bit ra, wa;
        we = w; re = r; din = d;
        @(posedge clk);
        ra = r && (q.size() > 0);
        wa = w && ((q.size() < D) || ra);
        if ((w && !wa) || (r && q.size() == 0)) m_err = 1'b1;
        m_valid = ra;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        q.delete(); m_err = 1'b0; m_valid = 1'b0; m_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; we = 1'b0; re = 1'b0; din = '0; ua = 4'd6; ub = 4'd2;
        q.delete(); m_err = 1'b0; m_valid = 1'b0; m_dout = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0", cnt0, cnt1); end
        checks++; if ({e0, ae0, f0, af0} !== 4'b1100) begin failures++; $display("FAIL reset_flags0 got=%b exp=1100", {e0, ae0, f0, af0}); end
        checks++; if ({e1, ae1, f1, af1} !== 4'b1100) begin failures++; $display("FAIL reset_flags1 got=%b exp=1100", {e1, ae1, f1, af1}); end
        checks++; if ({er0, er1, v0, v1} !== 4'b0000) begin failures++; $display("FAIL reset_err_valid got=%b exp=0000", {er0, er1, v0, v1}); end
        checks++; if (dout0 !== 10'h000 || dout1 !== 10'h000) begin failures++; $display("FAIL reset_dout got=%h/%h exp=000", dout0, dout1); end
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] words [8] = '{10'h091, 10'h04A, 10'h093, 10'h046, 10'h0B5, 10'h164, 10'h1E5, 10'h266};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, words[i]);
            checks++; if (int'(cnt0) != i + 1) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", cnt0, i + 1); end
            checks++; if (af0 !== (i + 1 >= 6) || f0 !== (i + 1 == 8)) begin failures++; $display("FAIL fill_af_full i=%0d got=%b%b", i, af0, f0); end
            checks++; if (v1 !== 1'b1 || dout1 !== words[0]) begin failures++; $display("FAIL fill_fwft_head got=%b/%h exp=1/%h", v1, dout1, words[0]); end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++; if (v0 !== 1'b1 || dout0 !== words[i]) begin failures++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, v0, dout0, words[i]); end
            if (i < 7) begin
                checks++; if (v1 !== 1'b1 || dout1 !== words[i + 1]) begin failures++; $display("FAIL drain_fwft i=%0d got=%b/%h exp=1/%h", i, v1, dout1, words[i + 1]); end
            end else begin
                checks++; if (v1 !== 1'b0 || e0 !== 1'b1 || e1 !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b%b%b exp=011", v1, e0, e1); end
            end
        end
        cycle(1'b0, 1'b0, '0);
        checks++; if (v0 !== 1'b0 || dout0 !== words[7]) begin failures++; $display("FAIL drain_hold got=%b/%h exp=0/%h", v0, dout0, words[7]); end
        checks++; if (er0 !== 1'b0) begin failures++; $display("FAIL drain_error got=%b exp=0", er0); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 10'h100 + 10'(i));
        cycle(1'b1, 1'b0, 10'h3FF);
        checks++; if (er0 !== 1'b1 || er1 !== 1'b1 || cnt0 !== 4'd8) begin failures++; $display("FAIL ovf_err got=%b%b cnt=%0d exp=11 cnt=8", er0, er1, cnt0); end
        cycle(1'b0, 1'b0, '0);
        checks++; if (er0 !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", er0); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++; if (dout0 === 10'h3FF || dout0 !== 10'h100 + 10'(i)) begin failures++; $display("FAIL ovf_data i=%0d got=%h exp=%h", i, dout0, 10'h100 + 10'(i)); end
        end
    endtask

    task automatic test_full_rw();
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 10'h010 + 10'(i));
        cycle(1'b1, 1'b1, 10'h155);
        checks++; if (cnt0 !== 4'd8 || f0 !== 1'b1 || er0 !== 1'b0) begin failures++; $display("FAIL frw_state got cnt=%0d full=%b err=%b exp 8/1/0", cnt0, f0, er0); end
        checks++; if (v0 !== 1'b1 || dout0 !== 10'h010) begin failures++; $display("FAIL frw_first got=%b/%h exp=1/010", v0, dout0); end
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] exp;
            exp = (i < 7) ? 10'h011 + 10'(i) : 10'h155;
            cycle(1'b0, 1'b1, '0);
            checks++; if (dout0 !== exp) begin failures++; $display("FAIL frw_order i=%0d got=%h exp=%h", i, dout0, exp); end
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        cycle(1'b1, 1'b0, 10'h0AB);
        cycle(1'b0, 1'b1, '0);
        checks++; if (er0 !== 1'b0 || dout0 !== 10'h0AB) begin failures++; $display("FAIL udf_pre got=%b/%h exp=0/0ab", er0, dout0); end
        cycle(1'b0, 1'b1, '0);
        checks++; if (er0 !== 1'b1 || dout0 !== 10'h0AB || cnt0 !== 4'd0 || v0 !== 1'b0) begin failures++; $display("FAIL udf_read got err=%b d=%h cnt=%0d v=%b", er0, dout0, cnt0, v0); end
        cycle(1'b1, 1'b1, 10'h0AA);
        checks++; if (cnt0 !== 4'd1 || er0 !== 1'b1 || v0 !== 1'b0) begin failures++; $display("FAIL udf_rw got cnt=%0d err=%b v=%b exp 1/1/0", cnt0, er0, v0); end
        checks++; if (v1 !== 1'b1 || dout1 !== 10'h0AA) begin failures++; $display("FAIL udf_rw_fwft got=%b/%h exp=1/0aa", v1, dout1); end
    endtask

    task automatic test_fwft();
        apply_reset();
        cycle(1'b1, 1'b0, 10'h291);
        checks++; if (v1 !== 1'b1 || dout1 !== 10'h291 || v0 !== 1'b0) begin failures++; $display("FAIL fwft_fall got=%b/%h v0=%b exp=1/291 v0=0", v1, dout1, v0); end
        cycle(1'b0, 1'b1, '0);
        checks++; if (e1 !== 1'b1 || v1 !== 1'b0) begin failures++; $display("FAIL fwft_pop got empty=%b valid=%b exp 1/0", e1, v1); end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 10'h300 + 10'(i));
        we = 1'b1; din = 10'h303;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (cnt1 !== 4'd0 || cnt0 !== 4'd0 || e1 !== 1'b1 || v1 !== 1'b0 || dout1 !== 10'h000) begin failures++; $display("FAIL fwft_mid_reset got cnt=%0d/%0d e=%b v=%b d=%h", cnt0, cnt1, e1, v1, dout1); end
        we = 1'b0;
        q.delete(); m_err = 1'b0; m_valid = 1'b0; m_dout = '0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 10'h0C3);
        checks++; if (v1 !== 1'b1 || dout1 !== 10'h0C3 || cnt1 !== 4'd1) begin failures++; $display("FAIL fwft_after_reset got=%b/%h cnt=%0d exp=1/0c3 cnt=1", v1, dout1, cnt1); end
        cycle(1'b0, 1'b1, '0);
        checks++; if (v0 !== 1'b1 || dout0 !== 10'h0C3 || e1 !== 1'b1) begin failures++; $display("FAIL fwft_no_stale got=%b/%h e=%b exp=1/0c3 e=1", v0, dout0, e1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) apply_reset();
            if (n % 40 == 0) begin
                ua = 4'($urandom_range(0, 8));
                ub = 4'($urandom_range(0, 8));
            end
            cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 10'($urandom));
            checks++; if (int'(cnt0) != q.size() || int'(cnt1) != q.size()) begin failures++; $display("FAIL rnd_count n=%0d got=%0d/%0d exp=%0d", n, cnt0, cnt1, q.size()); end
            checks++; if (f0 !== (q.size() == D) || e0 !== (q.size() == 0) || f1 !== f0 || e1 !== e0) begin failures++; $display("FAIL rnd_full_empty n=%0d got=%b%b%b%b", n, f0, e0, f1, e1); end
            checks++; if (af0 !== (q.size() >= int'(ua)) || ae0 !== (q.size() <= int'(ub)) || af1 !== af0 || ae1 !== ae0) begin failures++; $display("FAIL rnd_almost n=%0d got=%b%b ua=%0d ub=%0d size=%0d", n, af0, ae0, ua, ub, q.size()); end
            checks++; if (er0 !== m_err || er1 !== m_err) begin failures++; $display("FAIL rnd_error n=%0d got=%b/%b exp=%b", n, er0, er1, m_err); end
            checks++; if (v0 !== m_valid || dout0 !== m_dout) begin failures++; $display("FAIL rnd_reg_out n=%0d got=%b/%h exp=%b/%h", n, v0, dout0, m_valid, m_dout); end
            checks++; if (v1 !== (q.size() > 0) || (q.size() > 0 && dout1 !== q[0])) begin failures++; $display("FAIL rnd_fwft_out n=%0d got=%b/%h", n, v1, dout1); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        ua = 4'd6; ub = 4'd2;
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_fwft();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
